// File: rtl/i2c_reg_responder_pkg.sv
// Shared I2C constants: device addresses and the register-responder state encoding.
package i2c_reg_responder_pkg;

  localparam logic [6:0] ADV7513_ADDR      = 7'h39;
  localparam logic [6:0] CHIP_ADDR_DEFAULT = ADV7513_ADDR;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises raw SCL/SDA into clk and flags SCL edges plus START/STOP conditions.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Reset to the idle bus level so leaving reset never looks like an edge or a START.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= SYNC_STAGES'({scl_sync_q, scl_i});
      sda_sync_q <= SYNC_STAGES'({sda_sync_q, sda_i});
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_reg_responder.sv
// I2C target exposing a 256x8 register bank with an auto-incrementing pointer;
// the bank is also readable locally through loc_addr/loc_data.
module i2c_reg_responder
  import i2c_reg_responder_pkg::*;
#(
  parameter logic [6:0] CHIP_ADDR   = CHIP_ADDR_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oen,
  output logic       busy,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] loc_addr,
  output logic [7:0] loc_data
);

  logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
  state_e     state_q;
  logic [7:0] shift_q, ptr_q, wr_addr_q, wr_data_q, loc_data_q;
  logic [7:0] bank_q [256];
  logic [2:0] bit_cnt_q;
  logic       phase_q, rw_q, sda_oen_q, busy_q, wr_strobe_q;
  logic [7:0] rx_byte;
  logic       bank_we;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (scl_in),
    .sda_i      (sda_in),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  assign rx_byte = {shift_q[6:0], sda_s};
  assign bank_we = (state_q == ST_WDATA) && scl_rise && (bit_cnt_q == 3'd7);

  // NOTE: every bank entry is reset explicitly, so this must stay a flop array, not a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) bank_q[i] <= '0;
      loc_data_q <= '0;
    end else begin
      if (bank_we) bank_q[ptr_q] <= rx_byte;
      loc_data_q <= bank_q[loc_addr];
    end
  end

  // ACK states use phase_q: the first SCL fall drives/releases, the second leaves the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sda_oen_q   <= 1'b1;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      ptr_q       <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      phase_q     <= 1'b0;
      rw_q        <= 1'b0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (stop_det) begin
        state_q   <= ST_IDLE;
        sda_oen_q <= 1'b1;
        busy_q    <= 1'b0;
      end else if (start_det) begin
        state_q   <= ST_ADDR;
        sda_oen_q <= 1'b1;
        bit_cnt_q <= '0;
        phase_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR: if (scl_rise) begin
            shift_q   <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_byte[7:1] == CHIP_ADDR) begin
                rw_q    <= rx_byte[0];
                busy_q  <= 1'b1;
                state_q <= ST_ADDR_ACK;
              end else begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end
          end
          ST_REG: if (scl_rise) begin
            shift_q   <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ptr_q   <= rx_byte;
              state_q <= ST_REG_ACK;
            end
          end
          ST_WDATA: if (scl_rise) begin
            shift_q   <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              wr_strobe_q <= 1'b1;
              wr_addr_q   <= ptr_q;
              wr_data_q   <= rx_byte;
              ptr_q       <= ptr_q + 8'd1;
              state_q     <= ST_WDATA_ACK;
            end
          end
          ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: if (scl_fall) begin
            if (!phase_q) begin
              sda_oen_q <= 1'b0;
              phase_q   <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                state_q   <= ST_RDATA;
                shift_q   <= bank_q[ptr_q];
                sda_oen_q <= bank_q[ptr_q][7];
              end else begin
                sda_oen_q <= 1'b1;
                state_q   <= (state_q == ST_ADDR_ACK) ? ST_REG : ST_WDATA;
              end
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                ptr_q   <= ptr_q + 8'd1;
                state_q <= ST_RDATA_ACK;
              end
            end else if (scl_fall) begin
              shift_q   <= {shift_q[6:0], shift_q[7]};
              sda_oen_q <= shift_q[6];
            end
          end
          ST_RDATA_ACK: begin
            if (scl_fall) begin
              if (!phase_q) begin
                sda_oen_q <= 1'b1;
                phase_q   <= 1'b1;
              end else begin
                phase_q   <= 1'b0;
                state_q   <= ST_RDATA;
                shift_q   <= bank_q[ptr_q];
                sda_oen_q <= bank_q[ptr_q][7];
              end
            end else if (scl_rise && phase_q && sda_s) begin
              phase_q <= 1'b0;
              state_q <= ST_WAIT_STOP;
            end
          end
          ST_IDLE, ST_WAIT_STOP: ;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign sda_oen   = sda_oen_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign loc_data  = loc_data_q;

endmodule
